// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-stage dynamic branch predictor.
//   - Direct-mapped BTB: valid, tag and target per entry.
//   - Table of 2-bit saturating direction counters.
//   Fetch looks up pred_pc combinationally; execute reports resolved conditional
//   branches through the upd_* port, which trains the tables one cycle later.
//
// Configuration macro: BP_GSHARE_EN
//   Defined   : an IDX-bit global history register is XORed into the counter index
//               (gshare); history is updated at resolve time.
//   Undefined : bimodal counters indexed by PC only; pred_ghr is tied to 0 and
//               upd_ghr is ignored.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   pred_pc                    fetch PC to predict
//   pred_taken, pred_target    prediction (zero latency)
//   pred_ghr                   history snapshot travelling with the branch
//   upd_valid, upd_pc,
//   upd_taken, upd_target,
//   upd_pred_taken, upd_ghr    resolved-branch update from execute
//   mispredict                 registered one-cycle mispredict flag
//   mispred_cnt                wrapping mispredict counter
module branch_predictor #(
  parameter int ENTRIES = 64,
  localparam int IDX = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     pred_pc,
  output logic            pred_taken,
  output logic [31:0]     pred_target,
  output logic [IDX-1:0]  pred_ghr,
  input  logic            upd_valid,
  input  logic [31:0]     upd_pc,
  input  logic            upd_taken,
  input  logic [31:0]     upd_target,
  input  logic            upd_pred_taken,
  input  logic [IDX-1:0]  upd_ghr,
  output logic            mispredict,
  output logic [31:0]     mispred_cnt
);

  localparam int TAGW = 32 - IDX - 2;

  // Saturating step of a 2-bit direction counter toward the resolved outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic t);
    logic [1:0] n;
    if (t) begin
      n = (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      n = (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
    return n;
  endfunction

  logic             btb_valid_r  [ENTRIES];
  logic [TAGW-1:0]  btb_tag_r    [ENTRIES];
  logic [31:0]      btb_target_r [ENTRIES];
  logic [1:0]       ctr_r        [ENTRIES];
  logic             mispredict_r;
  logic [31:0]      mispred_cnt_r;

  logic [IDX-1:0]   pidx_s;
  logic [IDX-1:0]   uidx_s;
  logic [IDX-1:0]   cidx_p_s;
  logic [IDX-1:0]   cidx_u_s;
  logic [IDX-1:0]   ghr_s;
  logic             hit_s;
  logic             mis_s;

  assign pidx_s = pred_pc[IDX+1:2];
  assign uidx_s = upd_pc[IDX+1:2];
  assign mis_s  = upd_taken ^ upd_pred_taken;

`ifdef BP_GSHARE_EN
  logic [IDX-1:0] ghr_r;

  // Non-speculative global history: shifts in each resolved outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r <= {IDX{1'b0}};
    end else if (upd_valid) begin
      ghr_r <= {ghr_r[IDX-2:0], upd_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end

  assign ghr_s    = ghr_r;
  assign cidx_p_s = pidx_s ^ ghr_r;
  assign cidx_u_s = uidx_s ^ upd_ghr;
`else
  assign ghr_s    = {IDX{1'b0}};
  assign cidx_p_s = pidx_s;
  assign cidx_u_s = uidx_s;
`endif

  // Low PC bits (and upd_ghr in bimodal builds) carry no information here.
  logic unused_ok_s;
  assign unused_ok_s = ^{upd_ghr, pred_pc[1:0], upd_pc[1:0]};

  // Lookup from registered state only; a same-cycle update is not bypassed.
  always_comb begin
    hit_s       = btb_valid_r[pidx_s] && (btb_tag_r[pidx_s] == pred_pc[31:IDX+2]);
    pred_taken  = hit_s & ctr_r[cidx_p_s][1];
    pred_target = pred_taken ? btb_target_r[pidx_s] : pred_pc + 32'd4;
  end

  // BTB and counter training on a resolved branch; not-taken never invalidates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_tag_r[i]    <= {TAGW{1'b0}};
        btb_target_r[i] <= 32'd0;
        ctr_r[i]        <= 2'b01;
      end
    end else if (upd_valid) begin
      ctr_r[cidx_u_s] <= ctr_step(ctr_r[cidx_u_s], upd_taken);
      if (upd_taken) begin
        btb_valid_r[uidx_s]  <= 1'b1;
        btb_tag_r[uidx_s]    <= upd_pc[31:IDX+2];
        btb_target_r[uidx_s] <= upd_target;
      end
    end
  end

  // Mispredict pulse and wrapping counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_r  <= 1'b0;
      mispred_cnt_r <= 32'd0;
    end else if (upd_valid) begin
      mispredict_r  <= mis_s;
      mispred_cnt_r <= mispred_cnt_r + {31'd0, mis_s};
    end else begin
      mispredict_r  <= 1'b0;
      mispred_cnt_r <= mispred_cnt_r;
    end
  end

  assign pred_ghr    = ghr_s;
  assign mispredict  = mispredict_r;
  assign mispred_cnt = mispred_cnt_r;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage. It holds a direct-mapped branch target buffer (BTB) and a table of 2-bit saturating direction counters. Fetch asks it whether the instruction at the current PC is a taken branch and where it goes. The branch comparator in execute reports the resolved outcome back to it, so this block is the consumer of the comparator's taken/not-taken result and closes the loop from execute to fetch.

## Interface
- `ENTRIES`, 64: BTB and counter-table depth; power of two, ≥4. `IDX = $clog2(ENTRIES)`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pred_pc` input 32: fetch PC to predict.
- `pred_taken` output 1: predicted taken.
- `pred_target` output 32: predicted next PC.
- `pred_ghr` output IDX: history snapshot; fetch carries it down the pipe with the branch.
- `upd_valid` input 1: a resolved conditional branch, valid this cycle.
- `upd_pc` input 32: PC of the resolved branch.
- `upd_taken` input 1: resolved outcome (comparator `cmp`).
- `upd_target` input 32: resolved taken target.
- `upd_pred_taken` input 1: what was predicted for this branch.
- `upd_ghr` input IDX: the `pred_ghr` snapshot carried with the branch.
- `mispredict` output 1: registered; 1 for one cycle after an update whose outcome ≠ `upd_pred_taken`.
- `mispred_cnt` output 32: count of mispredictions; wraps at 2^32.

## Operation
- Index fields:
  - `pidx = pred_pc[IDX+1:2]`; `uidx = upd_pc[IDX+1:2]`.
  - Tag is `pc[31:IDX+2]`.
- BTB entry contents: valid bit, tag, 32-bit target.
- Counter states:
  - SN=00, WN=01, WT=10, ST=11.
  - Taken moves one state up, saturating at ST.
  - Not-taken moves one state down, saturating at SN.
- Lookup (combinational, from the current registered state):
  - `hit` = BTB[pidx] valid and tag match.
  - `pred_taken = hit & ctr[cidx_p][1]`.
  - `pred_target = pred_taken ? BTB[pidx].target : pred_pc + 32'd4`. The add is mod 2^32.
- Counter index:
  - `cidx_p = pidx` and `cidx_u = uidx` when history is disabled.
  - See Configuration for the gshare form.
- Update (on `upd_valid`):
  - The counter at `cidx_u` steps toward `upd_taken`.
  - If `upd_taken`, BTB[uidx] is written with valid=1, tag, and `upd_target`. This overwrites any alias.
  - Not-taken never invalidates a BTB entry.
- Mispredict:
  - On every `upd_valid`, `mispredict <= upd_taken ^ upd_pred_taken`.
  - When that value is 1, `mispred_cnt` increments.
  - `mispredict <= 0` in cycles without `upd_valid`.
- `upd_pc[1:0]` and `pred_pc[1:0]` are ignored.

## Timing
- Reset values:
  - All BTB valid bits = 0; tags and targets = 0.
  - All counters = WN (01).
  - GHR = 0; `mispredict` = 0; `mispred_cnt` = 0.
  - Consequence: `pred_taken` = 0 and `pred_target = pred_pc+4` immediately after reset.
- Prediction latency is zero cycles (combinational from `pred_pc`).
- An update becomes visible to lookup on the cycle after the edge that samples `upd_valid`.
- Simultaneous lookup and update to the same index: lookup returns the pre-update state. There is no bypass.
- Reset asserted mid-operation clears all state asynchronously. An update in flight is discarded.
- No backpressure: one update per cycle is always accepted.

## Configuration
- `BP_GSHARE_EN` defined:
  - An IDX-bit global history register (GHR) is added.
  - `pred_ghr = GHR`.
  - `cidx_p = pidx ^ GHR` and `cidx_u = uidx ^ upd_ghr`.
  - On `upd_valid`: `GHR <= {GHR[IDX-2:0], upd_taken}`. GHR is non-speculative and updated at resolve.
- `BP_GSHARE_EN` undefined:
  - No GHR; `pred_ghr` is tied to 0 and `upd_ghr` is ignored.
  - Counters are indexed by PC bits only (bimodal).

## Test plan
All scenarios use `ENTRIES=64`.
- **Reset defaults:** hold reset, release, drive `pred_pc=0x100` -> `pred_taken=0`, `pred_target=0x104`, `mispred_cnt=0`.
- **Train to taken (bimodal):** drive two updates, each `upd_pc=0x100`, `upd_taken=1`, `upd_target=0x80`, `upd_pred_taken=0`.
  - After the first -> `pred_taken=1`, `pred_target=0x80` (counter WT).
  - After the second -> counter ST, `mispred_cnt=2`, `mispredict` pulses each time.
- **Hysteresis:** from ST, one not-taken update at 0x100 -> `pred_taken` stays 1 (WT), target still 0x80; a second not-taken -> `pred_taken=0`, `pred_target=0x104`.
- **Alias:** train 0x100 taken -> 0x80, then a taken update at 0x200 (same index, different tag) -> lookup at 0x100 misses (`pred_taken=0`); lookup at 0x200 hits.
- **Same-cycle update/lookup:** at 0x100 from WN, in the same cycle drive `pred_pc=0x100` and a taken update at 0x100 -> that cycle `pred_taken=0`; next cycle `pred_taken=1`.
- **Gshare (`BP_GSHARE_EN`):** apply updates at 0x40 with outcomes 1,1,0 -> GHR=3'b...110. Then lookup at 0x40 uses counter index `0x10 ^ 0x06 = 0x16`, and `pred_ghr=0x06`.
